pwm_chan_axi_n: RTL and testbench
=================================

PWM_CHAN_AXI_N -- requirements
Module: pwm_chan_axi_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of PWM channels (legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 16, counter/period/duty width (legal 8..32).
REQ-003 SHALL have parameter ADDR_W, default 7, AXI4-Lite byte-address width; data width fixed at 32.
REQ-004 SHALL have ports: ACLK in 1 clock; ARESET in 1 reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have AXI4-Lite slave ports s_axi_aw{addr[ADDR_W],valid,ready}, w{data[32],strb[4],valid,ready}, b{resp[2],valid,ready}, ar{addr[ADDR_W],valid,ready}, r{data[32],resp[2],valid,ready}, standard directions.
REQ-006 SHALL have pwm_out out NUM_CH, registered PWM outputs.
REQ-007 SHALL have period_tick out 1, one-cycle pulse on counter wrap.

Function
REQ-008 SHALL map registers: 0x00 CTRL (bit0 GEN global enable, bit1 UPD update request), 0x04 PERIOD[CNT_W-1:0], 0x08 CH_EN[NUM_CH-1:0], 0x0C POL[NUM_CH-1:0], 0x10+4*i DUTY[i] for i<NUM_CH.
REQ-009 SHALL honour WSTRB per byte; bits above field width ignored on write, read as 0.
REQ-010 SHALL accept AW and W in either order or same cycle; one write outstanding; awready/wready each high for one cycle once both valid and no pending B.
REQ-011 SHALL assert bvalid the cycle after write acceptance, hold until bready.
REQ-012 SHALL assert arready one cycle when arvalid and no pending R; rvalid the following cycle, data stable until rready.
REQ-013 SHALL return resp 2'b00 for mapped addresses, 2'b10 (SLVERR) for unmapped; unmapped writes have no effect, unmapped reads return 0.
REQ-014 SHALL write PERIOD, DUTY[i] into shadow registers; readback returns shadow values.
REQ-015 SHALL copy all shadows to active registers on the ACLK edge where counter wraps and UPD=1, then clear UPD same edge.
REQ-016 SHALL, while GEN=0, hold counter at 0 and copy shadows to active every cycle (immediate update), UPD cleared.
REQ-017 SHALL count CNT_W-bit counter 0..PERIOD_act when GEN=1; at cnt==PERIOD_act next value 0, period_tick=1 next cycle.
REQ-018 SHALL drive pwm_out[i] registered = ((GEN & CH_EN[i] & (cnt < DUTY_act[i])) XOR POL[i]); one-cycle latency from cnt.
REQ-019 SHALL give 100% duty when DUTY_act[i] > PERIOD_act, 0% when DUTY_act[i]=0.
REQ-020 SHALL, with PERIOD_act=0, hold cnt at 0, pulse period_tick every cycle, output high iff DUTY_act[i]>0.
REQ-021 SHALL apply CH_EN and POL immediately (unshadowed), effective on pwm_out next cycle.
REQ-022 SHALL, on write to CTRL setting UPD the same cycle a wrap occurs, defer the copy to the next wrap.
REQ-023 SHALL read UPD as 1 while an update is pending.

Reset
REQ-024 SHALL, with ARESET=1 at ACLK edge, clear all registers (shadow, active, CTRL, CH_EN, POL), counter, period_tick=0, pwm_out=0, all AXI valid/ready=0.
REQ-025 SHALL abort any in-flight AXI transaction on reset with no response issued.
REQ-026 SHALL operate normally from the first edge with ARESET=0.

Verification
REQ-027 SHALL verify: write/read each mapped register with 0xFFFFFFFF -> read masked to field width, resp OKAY; read 0x7C with NUM_CH=8 -> 0, SLVERR.
REQ-028 SHALL verify: PERIOD=9, DUTY0=3, CH_EN=1, GEN=1 -> pwm_out[0] high 3 of every 10 cycles, period_tick every 10 cycles.
REQ-029 SHALL verify: while running, DUTY0=7 then UPD=1 -> old duty 3 persists to wrap, new duty 7 from next period, UPD reads 0 after.
REQ-030 SHALL verify: POL0=1, DUTY0=0 -> pwm_out[0] constant 1; DUTY0=10 with PERIOD=9, POL0=0 -> constant 1.
REQ-031 SHALL verify: W presented 3 cycles before AW, and AW/W simultaneous -> both complete, bvalid held until delayed bready.
REQ-032 SHALL verify: ARESET mid-write and mid-period -> outputs 0, registers read 0, no bvalid issued.

Source files
------------

// File: rtl/pwm_chan_axi_n.sv
// Multi-channel PWM generator with an AXI4-Lite register port.
// PERIOD/DUTY are double-buffered; CH_EN/POL take effect immediately.
module pwm_chan_axi_n #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 7
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              gen;
  logic              upd;
  logic [CNT_W-1:0]  period_sh;
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  duty_sh  [NUM_CH];
  logic [CNT_W-1:0]  duty_act [NUM_CH];
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] pol;

  int          wr_wi;
  int          rd_wi;
  logic        wr_ok;
  logic        rd_ok;
  logic [31:0] wr_val;
  logic        wr_fire;
  logic        rd_fire;
  logic        wrap;
  logic        unused_wr_bits;

  // Word view of a register as seen on the bus; fields are zero-extended.
  function automatic logic [31:0] reg_word(input int wi);
    logic [31:0] v;
    v = '0;
    case (wi)
      0: v = {30'd0, upd, gen};
      1: v = 32'(period_sh);
      2: v = 32'(ch_en);
      3: v = 32'(pol);
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (wi == 4 + i) v = 32'(duty_sh[i]);
      end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
    return v;
  endfunction

  always_comb begin
    wr_wi  = 32'(s_axi_awaddr[ADDR_W-1:2]);
    rd_wi  = 32'(s_axi_araddr[ADDR_W-1:2]);
    wr_ok  = (s_axi_awaddr[1:0] == 2'b00) && (wr_wi < 4 + NUM_CH);
    rd_ok  = (s_axi_araddr[1:0] == 2'b00) && (rd_wi < 4 + NUM_CH);
    wr_val = merge_strb(reg_word(wr_wi), s_axi_wdata, s_axi_wstrb);
  end

  // Bits of the merged word beyond the narrower fields are intentionally dropped.
  assign unused_wr_bits = ^wr_val;

  assign wr_fire = s_axi_awvalid & s_axi_awready & s_axi_wvalid & s_axi_wready;
  assign rd_fire = s_axi_arvalid & s_axi_arready;
  assign wrap    = gen && (cnt == period_act);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      gen           <= 1'b0;
      upd           <= 1'b0;
      period_sh     <= '0;
      period_act    <= '0;
      cnt           <= '0;
      ch_en         <= '0;
      pol           <= '0;
      pwm_out       <= '0;
      period_tick   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_awready & ~s_axi_bvalid;
      s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & ~s_axi_awready & ~s_axi_bvalid;
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      s_axi_arready <= s_axi_arvalid & ~s_axi_arready & ~s_axi_rvalid;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        s_axi_rdata  <= rd_ok ? reg_word(rd_wi) : '0;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      period_tick <= wrap;
      cnt         <= (gen && !wrap) ? cnt + CNT_W'(1) : '0;

      // The copy keys off the pending flag from before this edge, so an UPD
      // written on a wrap edge waits for the following wrap.
      if (!gen || (wrap && upd)) begin
        period_act <= period_sh;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
        upd <= 1'b0;
      end

      for (int i = 0; i < NUM_CH; i++)
        pwm_out[i] <= (gen & ch_en[i] & (cnt < duty_act[i])) ^ pol[i];

      if (wr_fire && wr_ok) begin
        case (wr_wi)
          0: begin
            gen <= wr_val[0];
            upd <= wr_val[1];
          end
          1: period_sh <= wr_val[CNT_W-1:0];
          2: ch_en     <= wr_val[NUM_CH-1:0];
          3: pol       <= wr_val[NUM_CH-1:0];
          default: begin
            for (int i = 0; i < NUM_CH; i++)
              if (wr_wi == 4 + i) duty_sh[i] <= wr_val[CNT_W-1:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_chan_axi_n.sv
// Self-checking bench for pwm_chan_axi_n: register table, PWM waveform model,
// AXI ordering corners and mid-transaction reset.
module tb_pwm_chan_axi_n;
  localparam int NUM_CH = 8;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 7;

  logic              tb_ACLK = 1'b0;
  logic              ARESET;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_tick;

  always #5 tb_ACLK = ~tb_ACLK;

  pwm_chan_axi_n #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .ACLK(tb_ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rd;
    logic [1:0]  resp;
  } vec_t;

  vec_t        vecs [10];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [33:0] r_exp;
  int          n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: responses are popped when the handshake is about to complete.
  always @(negedge tb_ACLK) begin
    if (s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) check("b_unexpected", 32'(s_axi_bvalid), 32'd0);
      else check("bresp", 32'(s_axi_bresp), 32'(bq.pop_front()));
    end
    if (s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) check("r_unexpected", 32'(s_axi_rvalid), 32'd0);
      else begin
        r_exp = rq.pop_front();
        check("rdata", s_axi_rdata, r_exp[31:0]);
        check("rresp", 32'(s_axi_rresp), 32'(r_exp[33:32]));
      end
    end
  end

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input int w_lead, input int b_delay);
    int k;
    bq.push_back(er);
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int i = 0; i < w_lead; i++) begin
      @(posedge tb_ACLK); #1;
      check("ready_before_aw", 32'(s_axi_wready | s_axi_awready), 32'd0);
    end
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    k = 0;
    while (!s_axi_awready && k < 20) begin @(posedge tb_ACLK); #1; k++; end
    check("aw_w_accept", 32'(s_axi_awready & s_axi_wready), 32'd1);
    @(posedge tb_ACLK); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("bvalid_after_accept", 32'(s_axi_bvalid), 32'd1);
    for (int i = 0; i < b_delay; i++) begin
      @(posedge tb_ACLK); #1;
      check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
    end
    s_axi_bready = 1'b1;
    k = 0;
    while (!s_axi_bvalid && k < 20) begin @(posedge tb_ACLK); #1; k++; end
    @(posedge tb_ACLK); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [6:0] a, input logic [31:0] ed, input logic [1:0] er);
    int k;
    rq.push_back({er, ed});
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    k = 0;
    while (!s_axi_arready && k < 20) begin @(posedge tb_ACLK); #1; k++; end
    check("ar_accept", 32'(s_axi_arready), 32'd1);
    @(posedge tb_ACLK); #1;
    s_axi_arvalid = 1'b0;
    k = 0;
    while (!s_axi_rvalid && k < 20) begin @(posedge tb_ACLK); #1; k++; end
    @(posedge tb_ACLK); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin @(posedge tb_ACLK); #1; k++; end while (!period_tick && k < 40);
    check("tick_seen", 32'(period_tick), 32'd1);
  endtask

  // Sample k=0 is the cycle period_tick is high; pwm_out then reflects cnt==PERIOD.
  task automatic watch_pwm(input int period, input int duty, input int cycles, input bit sync);
    int cs;
    if (sync) wait_tick();
    for (int k = 0; k < cycles; k++) begin
      if (k > 0) begin @(posedge tb_ACLK); #1; end
      cs = (k + period) % (period + 1);
      check("pwm0_wave", 32'(pwm_out[0]), 32'(cs < duty));
      check("tick_wave", 32'(period_tick), 32'((k % (period + 1)) == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7'h04, 32'hFFFF_FFFF, 4'hF, 32'h0000_FFFF, OK};
    vecs[1] = '{7'h04, 32'h0000_1234, 4'h1, 32'h0000_FF34, OK};
    vecs[2] = '{7'h08, 32'hFFFF_FFFF, 4'hF, 32'h0000_00FF, OK};
    vecs[3] = '{7'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0000_00FF, OK};
    vecs[4] = '{7'h10, 32'hFFFF_FFFF, 4'hF, 32'h0000_FFFF, OK};
    vecs[5] = '{7'h2C, 32'hFFFF_FFFF, 4'hF, 32'h0000_FFFF, OK};
    vecs[6] = '{7'h00, 32'hFFFF_FFFD, 4'hF, 32'h0000_0001, OK};
    vecs[7] = '{7'h7C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, SE};
    vecs[8] = '{7'h30, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, SE};
    vecs[9] = '{7'h0C, 32'h0000_AA00, 4'h2, 32'h0000_00FF, OK};

    ARESET = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) @(posedge tb_ACLK);
    #1 ARESET = 1'b0;

    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    check("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready}), 32'd0);
    axi_read(7'h00, 32'd0, OK);
    axi_read(7'h04, 32'd0, OK);
    axi_read(7'h08, 32'd0, OK);
    axi_read(7'h10, 32'd0, OK);

    for (int i = 0; i < 10; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].resp, 0, 0);
      axi_read(vecs[i].addr, vecs[i].rd, vecs[i].resp);
    end
    axi_write(7'h00, 32'd0, 4'hF, OK, 0, 0);
    axi_write(7'h08, 32'd0, 4'hF, OK, 0, 0);
    axi_write(7'h0C, 32'd0, 4'hF, OK, 0, 0);

    // W leads AW by three cycles, then simultaneous AW/W with a slow bready
    axi_write(7'h14, 32'h0000_0055, 4'hF, OK, 3, 0);
    axi_read(7'h14, 32'h0000_0055, OK);
    axi_write(7'h14, 32'h0000_A5A5, 4'hF, OK, 0, 4);
    axi_read(7'h14, 32'h0000_A5A5, OK);

    axi_write(7'h04, 32'd9, 4'hF, OK, 0, 0);
    axi_write(7'h10, 32'd3, 4'hF, OK, 0, 0);
    axi_write(7'h08, 32'd1, 4'hF, OK, 0, 0);
    axi_write(7'h00, 32'd1, 4'hF, OK, 0, 0);
    watch_pwm(9, 3, 20, 1'b1);

    // Shadowed duty change: old value must hold until the wrap that services UPD
    axi_write(7'h10, 32'd7, 4'hF, OK, 0, 0);
    axi_read(7'h10, 32'd7, OK);
    wait_tick();
    axi_write(7'h00, 32'd3, 4'hF, OK, 0, 0);
    axi_read(7'h00, 32'd3, OK);
    n = 0;
    while (!period_tick && n < 20) begin
      check("old_duty_holds", 32'(pwm_out[0]), 32'd0);
      @(posedge tb_ACLK); #1;
      n++;
    end
    check("upd_wrap_tick", 32'(period_tick), 32'd1);
    watch_pwm(9, 7, 12, 1'b0);
    axi_read(7'h00, 32'd1, OK);

    axi_write(7'h10, 32'd0, 4'hF, OK, 0, 0);
    axi_write(7'h0C, 32'd1, 4'hF, OK, 0, 0);
    axi_write(7'h00, 32'd3, 4'hF, OK, 0, 0);
    wait_tick(); wait_tick();
    @(posedge tb_ACLK); #1;
    for (int k = 0; k < 20; k++) begin
      check("pol_zero_duty", 32'(pwm_out[0]), 32'd1);
      @(posedge tb_ACLK); #1;
    end
    axi_write(7'h10, 32'd10, 4'hF, OK, 0, 0);
    axi_write(7'h0C, 32'd0, 4'hF, OK, 0, 0);
    axi_write(7'h00, 32'd3, 4'hF, OK, 0, 0);
    wait_tick(); wait_tick();
    @(posedge tb_ACLK); #1;
    for (int k = 0; k < 20; k++) begin
      check("duty_over_period", 32'(pwm_out[0]), 32'd1);
      @(posedge tb_ACLK); #1;
    end
    axi_read(7'h00, 32'd1, OK);

    // PERIOD=0: tick every cycle, output high only where duty is non-zero
    axi_write(7'h00, 32'd0, 4'hF, OK, 0, 0);
    axi_write(7'h04, 32'd0, 4'hF, OK, 0, 0);
    axi_write(7'h10, 32'd1, 4'hF, OK, 0, 0);
    axi_write(7'h14, 32'd0, 4'hF, OK, 0, 0);
    axi_write(7'h08, 32'd3, 4'hF, OK, 0, 0);
    axi_write(7'h00, 32'd1, 4'hF, OK, 0, 0);
    watch_pwm(0, 1, 5, 1'b0);
    check("pwm1_zero_duty", 32'(pwm_out[1]), 32'd0);

    axi_write(7'h00, 32'd0, 4'hF, OK, 0, 0);
    axi_write(7'h04, 32'd9, 4'hF, OK, 0, 0);
    axi_write(7'h10, 32'd3, 4'hF, OK, 0, 0);
    axi_write(7'h08, 32'd1, 4'hF, OK, 0, 0);
    axi_write(7'h00, 32'd1, 4'hF, OK, 0, 0);
    n = 0;
    while (!pwm_out[0] && n < 30) begin @(posedge tb_ACLK); #1; n++; end
    check("running_before_rst", 32'(pwm_out[0]), 32'd1);

    // Reset lands on the edge that would have accepted the write
    s_axi_awaddr = 7'h18; s_axi_wdata = 32'h0000_1234; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(posedge tb_ACLK); #1; n++; end
    check("aw_ready_pre_rst", 32'(s_axi_awready), 32'd1);
    ARESET = 1'b1;
    @(posedge tb_ACLK); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("rst_mid_pwm", 32'(pwm_out), 32'd0);
    check("rst_mid_tick", 32'(period_tick), 32'd0);
    check("rst_mid_ready", 32'({s_axi_awready, s_axi_wready}), 32'd0);
    @(posedge tb_ACLK); #1;
    ARESET = 1'b0;
    s_axi_bready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("no_bvalid_after_rst", 32'(s_axi_bvalid), 32'd0);
      check("pwm_after_rst", 32'(pwm_out), 32'd0);
      @(posedge tb_ACLK); #1;
    end
    s_axi_bready = 1'b0;
    axi_read(7'h00, 32'd0, OK);
    axi_read(7'h04, 32'd0, OK);
    axi_read(7'h08, 32'd0, OK);
    axi_read(7'h10, 32'd0, OK);
    axi_read(7'h18, 32'd0, OK);

    repeat (2) @(posedge tb_ACLK);
    #1;
    check("b_queue_drained", 32'(bq.size()), 32'd0);
    check("r_queue_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
